uart_receiver: RTL and testbench

Receive half of the UART link: de-serialises an asynchronous 8N1-style line into parallel bytes using the shared 16x oversampling tick from the baud-rate generator. It is the counterpart of `uart_transmitter` and sits between the board RX pin and the receive-side consumer, such as the interface FIFO. Each good frame produces a one-cycle `o_rx_done` strobe with the byte. A bad stop bit produces `o_frame_err` and no byte.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rx_sync.sv | 13 +
 rtl/uart_receiver.sv | 99 +++++++++
 tb/tb_uart_receiver.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and shared defaults for the UART transmit/receive pair
package uart_pkg;
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;
    localparam int OVERSAMPLE         = 16;
    localparam int START_MID          = 7;
    localparam int DEF_DATA_BITS      = 8;
    localparam int DEF_STP_BITS_TICKS = 16;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for an asynchronous, idle-high input
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);
    logic meta;
    // resets to the idle-high level so no false edge is seen after reset
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) {o_q, meta} <= 2'b11;
        else         {o_q, meta} <= {meta, i_d};
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled 8N1 deserialiser with framing-error detection
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS      = DEF_DATA_BITS,
    parameter int STP_BITS_TICKS = DEF_STP_BITS_TICKS
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_bd_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err,
    output logic                 o_rx_busy
);
    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    logic                 rx_s;
    logic [2:0]           state, state_n;
    logic [3:0]           tick_cnt, tick_n;
    logic [CW-1:0]        data_cnt, dcnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
    logic                 done_n, ferr_n;

    uart_rx_sync u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    assign o_rx_busy = state != IDLE;

    // registered FSMD state; strobes are registered so they follow the stop sample
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            data_cnt    <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_n;
            tick_cnt    <= tick_n;
            data_cnt    <= dcnt_n;
            shreg       <= shreg_n;
            o_data      <= data_n;
            o_rx_done   <= done_n;
            o_frame_err <= ferr_n;
        end

    // next-state logic: mid-bit sampling driven by the oversampling tick
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        dcnt_n  = data_cnt;
        shreg_n = shreg;
        data_n  = o_data;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: if (!rx_s) begin
                state_n = START;
                tick_n  = '0;
            end
            START: if (i_bd_tick) begin
                tick_n = tick_cnt + 4'd1;
                if (tick_cnt == 4'(START_MID)) begin
                    state_n = rx_s ? IDLE : DATA;
                    tick_n  = '0;
                    dcnt_n  = '0;
                end
            end
            DATA: if (i_bd_tick) begin
                tick_n = tick_cnt + 4'd1;
                if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    tick_n  = '0;
                    state_n = (data_cnt == CW'(DATA_BITS - 1)) ? STOP : DATA;
                    dcnt_n  = (data_cnt == CW'(DATA_BITS - 1)) ? data_cnt : data_cnt + CW'(1);
                end
            end
            STOP: if (i_bd_tick) begin
                tick_n = tick_cnt + 4'd1;
                if (tick_cnt == 4'(STP_BITS_TICKS - 1)) begin
                    tick_n  = '0;
                    state_n = rx_s ? IDLE : WAIT_HIGH;
                    data_n  = rx_s ? shreg : o_data;
                    done_n  = rx_s;
                    ferr_n  = !rx_s;
                end
            end
            WAIT_HIGH: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed self-checking bench for uart_receiver
module tb_uart_receiver;
    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_rx = 1'b1;
    logic [1:0] div = 2'd0;
    logic       i_bd_tick;
    logic [7:0] o_data;
    logic       o_rx_done, o_frame_err, o_rx_busy;
    int         vectors = 0, miscompares = 0;
    int         nerr = 0, both = 0, wide = 0, busy_done = 0;
    logic       prev_done = 1'b0;
    logic [7:0] got[$];

    uart_receiver dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_bd_tick   (i_bd_tick),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_rx_done   (o_rx_done),
        .o_frame_err (o_frame_err),
        .o_rx_busy   (o_rx_busy)
    );

    always #5 i_clk = ~i_clk;

    // one tick every 4 clocks
    always @(posedge i_clk) div <= div + 2'd1;
    assign i_bd_tick = div == 2'd3;

    // record strobes and protocol violations away from the active edge
    always @(negedge i_clk) begin
        if (i_reset) prev_done = 1'b0;
        else begin
            if (o_rx_done) got.push_back(o_data);
            if (o_frame_err) nerr++;
            if (o_rx_done && o_frame_err) both++;
            if (o_rx_done && prev_done) wide++;
            if (o_rx_done && o_rx_busy) busy_done++;
            prev_done = o_rx_done;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] at(input int i);
        return (i < got.size()) ? {24'h0, got[i]} : 32'hxxxxxxxx;
    endfunction

    task automatic ticks(input int n);
        repeat (n * 4) @(posedge i_clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        i_rx = 1'b0;
        ticks(16);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            ticks(16);
        end
        i_rx = stop;
        ticks(16);
    endtask

    initial begin
        logic [7:0] v;
        repeat (3) @(posedge i_clk);
        #2;
        check("rst_data", {24'h0, o_data}, 32'h0);
        check("rst_done", {31'h0, o_rx_done}, 32'h0);
        check("rst_ferr", {31'h0, o_frame_err}, 32'h0);
        check("rst_busy", {31'h0, o_rx_busy}, 32'h0);
        i_reset = 1'b0;
        ticks(4);
        // good frame
        send(8'hA5, 1'b1);
        ticks(8);
        check("good_cnt", got.size(), 1);
        check("good_byte", at(0), 32'hA5);
        check("good_odata", {24'h0, o_data}, 32'hA5);
        check("good_ferr", nerr, 0);
        check("good_busy", {31'h0, o_rx_busy}, 32'h0);
        // back-to-back
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h3C, 1'b1);
        ticks(8);
        check("b2b_cnt", got.size(), 4);
        check("b2b_0", at(1), 32'h00);
        check("b2b_1", at(2), 32'hFF);
        check("b2b_2", at(3), 32'h3C);
        // false start: ~3 tick glitch
        i_rx = 1'b0;
        repeat (4) @(posedge i_clk);
        #2;
        check("glitch_busy", {31'h0, o_rx_busy}, 32'h1);
        ticks(2);
        i_rx = 1'b1;
        ticks(40);
        check("glitch_cnt", got.size(), 4);
        check("glitch_ferr", nerr, 0);
        check("glitch_idle", {31'h0, o_rx_busy}, 32'h0);
        check("glitch_odata", {24'h0, o_data}, 32'h3C);
        // framing error then long low, release, good frame
        send(8'h55, 1'b0);
        ticks(40);
        check("ferr_wait", {31'h0, o_rx_busy}, 32'h1);
        check("ferr_cnt", nerr, 1);
        check("ferr_nodone", got.size(), 4);
        check("ferr_odata", {24'h0, o_data}, 32'h3C);
        i_rx = 1'b1;
        ticks(16);
        check("ferr_idle", {31'h0, o_rx_busy}, 32'h0);
        send(8'h81, 1'b1);
        ticks(8);
        check("after_cnt", got.size(), 5);
        check("after_byte", at(4), 32'h81);
        check("after_ferr", nerr, 1);
        // reset after data bit 3 of 0xC3
        v = 8'hC3;
        i_rx = 1'b0;
        ticks(16);
        for (int i = 0; i < 4; i++) begin
            i_rx = v[i];
            ticks(16);
        end
        #3 i_reset = 1'b1;
        #1;
        check("mid_rst_data", {24'h0, o_data}, 32'h0);
        check("mid_rst_done", {31'h0, o_rx_done}, 32'h0);
        check("mid_rst_ferr", {31'h0, o_frame_err}, 32'h0);
        check("mid_rst_busy", {31'h0, o_rx_busy}, 32'h0);
        i_rx = 1'b1;
        ticks(2);
        i_reset = 1'b0;
        ticks(16);
        check("post_rst_cnt", got.size(), 5);
        send(8'h12, 1'b1);
        ticks(8);
        check("post_rst_cnt2", got.size(), 6);
        check("post_rst_byte", at(5), 32'h12);
        // stream of incrementing bytes
        for (int i = 0; i < 32; i++) send(8'(i), 1'b1);
        ticks(8);
        check("stream_cnt", got.size(), 38);
        for (int i = 0; i < 32; i++) check("stream_byte", at(6 + i), i);
        check("stream_ferr", nerr, 1);
        check("done_and_ferr", both, 0);
        check("done_width", wide, 0);
        check("done_busy", busy_done, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
